// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory, redirect and decoded-instruction handshake bundle
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [6:0]         opcode;
  logic [2:0]         rsrc;
  logic [2:0]         rdst;
  logic [15:0]        imm;
  logic [ADDR_W-1:0]  pc_out;
  logic               halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid,
    input  redirect, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output opcode, rsrc, rdst, imm, pc_out, halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid,
    output redirect, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  opcode, rsrc, rdst, imm, pc_out, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetches one- or two-word instructions and issues decoded fields downstream
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH1, FETCH2, ISSUE, HALTED} state_t;

  localparam logic [6:0] OP_HLT = 7'b1100001;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [2:0]         rsrc_q, rsrc_d;
  logic [2:0]         rdst_q, rdst_d;
  logic [15:0]        imm_q, imm_d;

  logic [INSTR_W-1:0] word;
  logic               req;
  logic               xfer;
  logic               word_is_imm;

  assign word        = bus.imem_rdata;
  assign xfer        = req && bus.imem_valid;
  assign word_is_imm = (word[15:14] == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH1;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      opcode_q <= '0;
      rsrc_q   <= '0;
      rdst_q   <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      opcode_q <= opcode_d;
      rsrc_q   <= rsrc_d;
      rdst_q   <= rdst_d;
      imm_q    <= imm_d;
    end
  end

  // Redirect outranks everything except HALTED; a concurrent issue handshake still completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH1: if (xfer) state_d = word_is_imm ? FETCH2 : ISSUE;
      FETCH2: if (xfer) state_d = ISSUE;
      ISSUE:  if (bus.instr_ready) state_d = (opcode_q == OP_HLT) ? HALTED : FETCH1;
      HALTED: state_d = HALTED;
      default: state_d = FETCH1;
    endcase
    if (bus.redirect && state_q != HALTED) state_d = FETCH1;
  end

  always_comb begin
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    opcode_d = opcode_q;
    rsrc_d   = rsrc_q;
    rdst_d   = rdst_q;
    imm_d    = imm_q;
    if (bus.redirect && state_q != HALTED) begin
      pc_d = bus.redirect_pc;
    end else if (xfer && state_q == FETCH1) begin
      opcode_d = word[15:9];
      rsrc_d   = word[8:6];
      rdst_d   = word[5:3];
      pc_out_d = pc_q;
      pc_d     = pc_q + 1'b1;
      if (!word_is_imm) imm_d = '0;
    end else if (xfer && state_q == FETCH2) begin
      imm_d = word[15:0];
      pc_d  = pc_q + 1'b1;
    end
  end

  always_comb begin
    req             = ((state_q == FETCH1) || (state_q == FETCH2)) && !reset;
    bus.imem_req    = req;
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == ISSUE);
    bus.halted      = (state_q == HALTED);
    bus.opcode      = opcode_q;
    bus.rsrc        = rsrc_q;
    bus.rdst        = rdst_q;
    bus.imm         = imm_q;
    bus.pc_out      = pc_out_q;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized checks of instr_fetch_unit against a program-walk model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0010)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] mem [0:65535];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] mpc, w, w2, nxt;
  logic        m_imm;
  int          accepted;

  initial begin
    bus.imem_valid  = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // reset state
    repeat (2) @(negedge clk);
    chk("req_in_reset", bus.imem_req, 1'b0);
    reset = 1'b0;
    #1;
    chk("req_after_rst", bus.imem_req, 1'b1);
    chk("addr_after_rst", bus.imem_addr, 16'h0010);
    chk("valid_after_rst", bus.instr_valid, 1'b0);
    chk("halted_after_rst", bus.halted, 1'b0);
    chk("fields_after_rst", {bus.opcode, bus.rsrc, bus.rdst, bus.imm, bus.pc_out}, {7'd0, 3'd0, 3'd0, 16'd0, 16'h0010});

    // single-word ADD, zero wait
    mem[16'h0010] = 16'h1A28;
    mem[16'h0011] = 16'h4008;
    mem[16'h0012] = 16'h1234;
    bus.imem_valid  = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("add_valid", bus.instr_valid, 1'b1);
    chk("add_fields", {bus.opcode, bus.rsrc, bus.rdst, bus.imm, bus.pc_out}, {7'b0001101, 3'd0, 3'd5, 16'd0, 16'h0010});
    chk("add_no_req", bus.imem_req, 1'b0);
    @(negedge clk);
    chk("add_next_addr", bus.imem_addr, 16'h0011);
    chk("add_valid_clr", bus.instr_valid, 1'b0);

    // IADD with 3 wait cycles on word2, then backpressure
    @(negedge clk);
    bus.imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("iadd_wait_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0012});
      chk("iadd_wait_valid", bus.instr_valid, 1'b0);
    end
    bus.imem_valid  = 1'b1;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    chk("iadd_fields", {bus.instr_valid, bus.opcode, bus.imm, bus.pc_out}, {1'b1, 7'b0100000, 16'h1234, 16'h0011});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.instr_valid, bus.imem_req, bus.opcode, bus.imm, bus.pc_out}, {1'b1, 1'b0, 7'b0100000, 16'h1234, 16'h0011});
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {bus.instr_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 16'h0013});

    // redirect during FETCH2 wait and during ISSUE
    bus.instr_ready = 1'b0;
    mem[16'h0013] = 16'h4010;
    mem[16'h0014] = 16'h5555;
    mem[16'h0200] = 16'h0650;
    mem[16'h0201] = 16'hC200;
    mem[16'h0300] = 16'hC200;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    @(negedge clk);
    chk("f2_wait_addr", bus.imem_addr, 16'h0014);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    bus.imem_valid  = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    chk("redir_f2", {bus.instr_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 16'h0200});
    @(negedge clk);
    chk("redir_target_issue", {bus.instr_valid, bus.opcode, bus.rsrc, bus.rdst, bus.imm, bus.pc_out},
        {1'b1, 7'b0000011, 3'd1, 3'd2, 16'd0, 16'h0200});
    bus.redirect = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    chk("redir_issue", {bus.instr_valid, bus.imem_addr}, {1'b0, 16'h0200});

    // HLT overridden by concurrent redirect, then real HLT
    bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("hlt_issue", {bus.instr_valid, bus.opcode, bus.pc_out}, {1'b1, 7'b1100001, 16'h0201});
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0300;
    @(negedge clk);
    bus.redirect = 1'b0;
    chk("hlt_redir", {bus.halted, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 16'h0300});
    @(negedge clk);
    chk("hlt2_issue", {bus.instr_valid, bus.opcode}, {1'b1, 7'b1100001});
    @(negedge clk);
    chk("halted", {bus.halted, bus.imem_req, bus.instr_valid}, {1'b1, 1'b0, 1'b0});
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halted_hold", {bus.halted, bus.imem_req, bus.instr_valid}, {1'b1, 1'b0, 1'b0});
    end
    bus.redirect = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_req_low", {bus.imem_req, bus.halted}, {1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_recover", {bus.imem_req, bus.imem_addr, bus.halted}, {1'b1, 16'h0010, 1'b0});

    // immediate instruction straddling the top of the address space
    bus.instr_ready = 1'b0;
    mem[16'hFFFF]   = 16'h4008;
    mem[16'h0000]   = 16'hBEEF;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    @(negedge clk);
    bus.redirect = 1'b0;
    chk("wrap_w1_addr", bus.imem_addr, 16'hFFFF);
    @(negedge clk);
    chk("wrap_w2_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});
    @(negedge clk);
    chk("wrap_issue", {bus.instr_valid, bus.opcode, bus.imm, bus.pc_out}, {1'b1, 7'b0100000, 16'hBEEF, 16'hFFFF});
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("wrap_next", bus.imem_addr, 16'h0001);

    // randomized program walk with wait states, backpressure and redirects
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:9] == 7'b1100001) w[9] = 1'b0;
      mem[i] = w;
    end
    bus.imem_valid  = 1'b0;
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mpc = 16'h0010;
    accepted = 0;
    for (int cyc = 0; cyc < 4000 && accepted < 200; cyc++) begin
      @(negedge clk);
      bus.imem_valid  = ($urandom_range(0, 3) != 0);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.redirect    = ($urandom_range(0, 29) == 0);
      bus.redirect_pc = 16'($urandom);
      if (bus.instr_valid && bus.instr_ready) begin
        w     = mem[mpc];
        m_imm = (w[15:14] == 2'b01);
        nxt   = mpc + 16'd1;
        w2    = m_imm ? mem[nxt] : 16'd0;
        chk("rand_instr", {bus.opcode, bus.rsrc, bus.rdst, bus.imm, bus.pc_out},
            {w[15:9], w[8:6], w[5:3], w2, mpc});
        mpc = m_imm ? mpc + 16'd2 : mpc + 16'd1;
        accepted++;
      end
      if (bus.redirect) mpc = bus.redirect_pc;
    end
    bus.redirect = 1'b0;
    chk("rand_progress", 64'(accepted >= 200), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetches instruction words from instruction memory and presents decoded fields (7-bit opcode, register fields, optional immediate) to the control unit through a valid/ready handshake. It sits upstream of the control unit and acts as the producer of the opcode stream that the control unit consumes. It handles two-word (immediate) instructions, branch redirects, and HLT. A multi-state FSM sequences the work, with one memory request outstanding at a time.

Parameters:
ADDR_W, 16, instruction address width; PC wraps modulo 2^ADDR_W
INSTR_W, 16, instruction word width (fixed field layout below requires 16)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  read request; address on imem_addr
imem_addr  out  ADDR_W  read address (current PC)
imem_rdata  in  INSTR_W  read data for the address presented this cycle
imem_valid  in  1  imem_rdata valid; sampled only when imem_req=1
redirect  in  1  load redirect_pc, flush current fetch/issue
redirect_pc  in  ADDR_W  redirect target
instr_valid  out  1  instruction fields valid
instr_ready  in  1  control unit accepts instruction
opcode  out  7  word1[15:9]
rsrc  out  3  word1[8:6]
rdst  out  3  word1[5:3]
imm  out  16  second word for immediate instructions, else 0
pc_out  out  ADDR_W  address of word1 of the issued instruction
halted  out  1  HLT issued; fetch stopped

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=FETCH1, pc=RESET_PC, instr_valid=0, opcode/rsrc/rdst/imm=0, pc_out=RESET_PC, halted=0.
- imem_req is driven by the FSM: 1 in FETCH1/FETCH2 and reset=0; 0 otherwise. imem_addr=pc at all times.
- Memory contract: a transfer occurs in any cycle with imem_req && imem_valid. Data belongs to the address presented in that same cycle. Any number of wait cycles is allowed, and imem_req is held with a stable address until the transfer.
- Immediate instruction: opcode[6:5]==2'b01 (e.g. IADD 0100000). All other opcodes are single-word.
- States:
  - FETCH1: on transfer, latch word1 fields and pc_out<=pc, then pc<=pc+1. If immediate, go to FETCH2; else set imm<=0 and go to ISSUE.
  - FETCH2: on transfer, imm<=imem_rdata, pc<=pc+1, go to ISSUE.
  - ISSUE: instr_valid=1 and all fields are held stable until instr_ready.
    - On transfer with opcode 1100001 (HLT), go to HALTED.
    - On any other transfer, go to FETCH1.
    - instr_valid is cleared on the clock edge that completes the transfer.
  - HALTED: imem_req=0, instr_valid=0, halted=1. Only reset exits this state; redirect is ignored.
- Latency: with zero-wait memory, a single-word instruction shows instr_valid 1 cycle after its FETCH1 transfer edge. Max throughput is 1 single-word instruction per 2 cycles and 1 immediate instruction per 3 cycles. Bubbles are permitted.
- Redirect (any state except HALTED) has priority over all other events in that cycle:
  - pc<=redirect_pc, state<=FETCH1, instr_valid<=0.
  - Memory data in that cycle is discarded.
  - An instruction being issued in that same cycle with instr_ready=1 still counts as transferred. Its HLT effect is overridden by redirect, and the next state is FETCH1.
- PC wraps from 2^ADDR_W-1 to 0, including between word1 and word2 of an immediate instruction.
- Reset mid-operation: immediate return to reset values. The in-flight request is abandoned, and imem_req is 0 while reset=1.
- Unknown opcodes are passed through unmodified as single-word instructions.

Test Plan:
1. Reset with RESET_PC=0x0010 -> imem_req=0 during reset. First cycle after release: imem_req=1, imem_addr=0x0010; instr_valid=0, halted=0.
2. Zero-wait memory, word 0x1A28 (ADD, opcode 0001101, rsrc=0, rdst=5) at 0x0010, instr_ready=1 -> one cycle later: instr_valid=1, opcode=0001101, rdst=5, imm=0, pc_out=0x0010; next fetch at 0x0011.
3. IADD: word1 0x4008 then 0x1234, with 3 wait cycles on word2 -> imem_addr held for 3 cycles. Then instr_valid with opcode=0100000, imm=0x1234; PC advances by 2.
4. Backpressure: instr_ready=0 for 5 cycles -> instr_valid stays 1, fields stable, imem_req=0. Release ready -> single transfer, then the next fetch begins.
5. Redirect to 0x0200 during FETCH2 wait and during ISSUE -> instr_valid drops next cycle, next imem_addr=0x0200, and no stale immediate is issued.
6. HLT 0xC200 accepted -> halted=1, imem_req=0 indefinitely; redirect ignored. Reset recovers to RESET_PC. Separately, word1 of an immediate instruction at 0xFFFF fetches word2 from 0x0000.
